// File: rtl/fpu_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_pipe_if : operand-issue / result handshake bundle for fpu_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
interface fpu_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   FPUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic [2:0]   flags;

  // slave: the pipe itself; master: the issuing/consuming side
  modport slave (
    input  in_valid, a, b, FPUControl, out_ready,
    output in_ready, out_valid, Result, flags
  );
  modport master (
    output in_valid, a, b, FPUControl, out_ready,
    input  in_ready, out_valid, Result, flags
  );
endinterface
`default_nettype wire

// File: rtl/fpu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_pipe : 3-stage pipelined FP add/sub/mul, valid/ready, FTZ, truncating
// Rev 1.0
// ----------------------------------------------------------------------------
module fpu_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  wire logic   clk,
  input  wire logic   reset,
  fpu_pipe_if.slave   bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = EXP_W + 2;
  localparam int GW  = MAN_W + 4;
  localparam int SW  = MAN_W + 5;
  localparam int PW  = 2 * MAN_W + 2;
  localparam int LZW = $clog2(SW);

  localparam logic [EXP_W-1:0]     C_EMAX   = '1;
  localparam logic signed [XW-1:0] C_BIAS   = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] C_EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] C_XZERO  = '0;
  localparam logic [W-1:0]         C_QNAN   = {1'b0, C_EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic w_stall, w_en;
  assign w_stall      = bus.out_valid & ~bus.out_ready;
  assign w_en         = ~w_stall;
  assign bus.in_ready = w_en;

  // ---------------- stage 1: unpack, classify, resolve specials ----------------
  logic               w_sa, w_sb, w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_mul, w_rsv;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W-1:0]   w_fa, w_fb;
  logic signed [XW-1:0] w_mexp;
  logic               w_spec;
  logic [W-1:0]       w_sres;
  logic [2:0]         w_sflg;

  assign w_sa   = bus.a[W-1];
  assign w_ea   = bus.a[W-2 -: EXP_W];
  assign w_fa   = bus.a[MAN_W-1:0];
  assign w_sb   = bus.b[W-1] ^ (bus.FPUControl == 2'b01);
  assign w_eb   = bus.b[W-2 -: EXP_W];
  assign w_fb   = bus.b[MAN_W-1:0];
  assign w_za   = (w_ea == '0);
  assign w_zb   = (w_eb == '0);
  assign w_ia   = (w_ea == C_EMAX) && (w_fa == '0);
  assign w_ib   = (w_eb == C_EMAX) && (w_fb == '0);
  assign w_na   = (w_ea == C_EMAX) && (w_fa != '0);
  assign w_nb   = (w_eb == C_EMAX) && (w_fb != '0);
  assign w_mul  = (bus.FPUControl == 2'b10);
  assign w_rsv  = (bus.FPUControl == 2'b11);
  assign w_mexp = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - C_BIAS;

  // Zero operands (including flushed subnormals) are resolved here exactly
  always_comb begin
    w_spec = 1'b1;
    w_sres = C_QNAN;
    w_sflg = 3'b000;
    if (w_rsv) begin
      w_sflg = 3'b100;
    end else if (w_na || w_nb) begin
      w_sflg = 3'b000;
    end else if (w_mul) begin
      if ((w_ia && w_zb) || (w_za && w_ib)) w_sflg = 3'b100;
      else if (w_ia || w_ib)                 w_sres = {w_sa ^ w_sb, C_EMAX, {MAN_W{1'b0}}};
      else if (w_za || w_zb)                 w_sres = {w_sa ^ w_sb, {(W-1){1'b0}}};
      else                                   w_spec = 1'b0;
    end else begin
      if (w_ia && w_ib && (w_sa != w_sb)) w_sflg = 3'b100;
      else if (w_ia)                      w_sres = {w_sa, C_EMAX, {MAN_W{1'b0}}};
      else if (w_ib)                      w_sres = {w_sb, C_EMAX, {MAN_W{1'b0}}};
      else if (w_za && w_zb)              w_sres = {w_sa & w_sb, {(W-1){1'b0}}};
      else if (w_za)                      w_sres = {w_sb, w_eb, w_fb};
      else if (w_zb)                      w_sres = {w_sa, w_ea, w_fa};
      else                                w_spec = 1'b0;
    end
  end

  logic                 r1_v, r1_mul, r1_spec, r1_sa, r1_sb;
  logic [W-1:0]         r1_sres;
  logic [2:0]           r1_sflg;
  logic [EXP_W-1:0]     r1_ea, r1_eb;
  logic [MAN_W:0]       r1_ma, r1_mb;
  logic signed [XW-1:0] r1_mexp;

  // ---------------- stage 2: swap/align/add or multiply ----------------
  logic             w_a_big, w_s_big, w_s_sm, w_eff_sub;
  logic [EXP_W-1:0] w_e_big, w_e_sm, w_diff;
  logic [MAN_W:0]   w_m_big, w_m_sm;
  logic [GW-1:0]    w_sm_x, w_big_x, w_al;
  logic [SW-1:0]    w_sum;
  logic [PW-1:0]    w_prod;

  assign w_a_big   = {r1_ea, r1_ma} >= {r1_eb, r1_mb};
  assign w_s_big   = w_a_big ? r1_sa : r1_sb;
  assign w_s_sm    = w_a_big ? r1_sb : r1_sa;
  assign w_e_big   = w_a_big ? r1_ea : r1_eb;
  assign w_e_sm    = w_a_big ? r1_eb : r1_ea;
  assign w_m_big   = w_a_big ? r1_ma : r1_mb;
  assign w_m_sm    = w_a_big ? r1_mb : r1_ma;
  assign w_diff    = w_e_big - w_e_sm;
  assign w_sm_x    = {w_m_sm, 3'b000};
  assign w_big_x   = {w_m_big, 3'b000};
  assign w_eff_sub = w_s_big ^ w_s_sm;

  // Bits shifted out of the smaller operand collapse into a sticky LSB
  always_comb begin
    if ({{(32-EXP_W){1'b0}}, w_diff} > 32'(MAN_W + 3))
      w_al = {{(GW-1){1'b0}}, 1'b1};
    else
      w_al = (w_sm_x >> w_diff) |
             {{(GW-1){1'b0}}, |(w_sm_x & ~({GW{1'b1}} << w_diff))};
  end

  assign w_sum  = w_eff_sub ? ({1'b0, w_big_x} - {1'b0, w_al})
                            : ({1'b0, w_big_x} + {1'b0, w_al});
  assign w_prod = PW'(r1_ma) * PW'(r1_mb);

  logic                 r2_v, r2_mul, r2_spec, r2_sign;
  logic [W-1:0]         r2_sres;
  logic [2:0]           r2_sflg;
  logic signed [XW-1:0] r2_exp;
  logic [SW-1:0]        r2_sum;
  logic [PW-1:0]        r2_prod;

  // ---------------- stage 3: normalise, range check, pack ----------------
  logic [LZW-1:0]       w_lz;
  logic [MAN_W-1:0]     w_mant;
  logic signed [XW-1:0] w_nexp;
  logic [W-1:0]         w_res;
  logic [2:0]           w_flg;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < SW; i++)
      if (r2_sum[i]) w_lz = LZW'(SW - 1 - i);
  end

  always_comb begin
    if (r2_mul) begin
      w_mant = r2_prod[PW-1] ? MAN_W'(r2_prod >> (MAN_W + 1)) : MAN_W'(r2_prod >> MAN_W);
      w_nexp = r2_exp + (r2_prod[PW-1] ? XW'(1) : XW'(0));
    end else begin
      w_mant = MAN_W'((r2_sum << w_lz) >> 4);
      w_nexp = r2_exp + XW'(1) - XW'(w_lz);
    end
  end

  always_comb begin
    w_res = {r2_sign, w_nexp[EXP_W-1:0], w_mant};
    w_flg = 3'b000;
    if (r2_spec) begin
      w_res = r2_sres;
      w_flg = r2_sflg;
    end else if (!r2_mul && (r2_sum == '0)) begin
      w_res = '0;
    end else if (w_nexp >= C_EMAX_X) begin
      w_res = {r2_sign, C_EMAX, {MAN_W{1'b0}}};
      w_flg = 3'b010;
    end else if (w_nexp <= C_XZERO) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
      w_flg = 3'b001;
    end
  end

  logic         r3_v;
  logic [W-1:0] r3_res;
  logic [2:0]   r3_flg;

  assign bus.out_valid = r3_v;
  assign bus.Result    = r3_res;
  assign bus.flags     = r3_flg;

  // Data registers load only behind a valid token so Result idles on the last value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_v <= 1'b0; r1_mul <= 1'b0; r1_spec <= 1'b0; r1_sa <= 1'b0; r1_sb <= 1'b0;
      r1_sres <= '0; r1_sflg <= '0; r1_ea <= '0; r1_eb <= '0;
      r1_ma <= '0; r1_mb <= '0; r1_mexp <= '0;
      r2_v <= 1'b0; r2_mul <= 1'b0; r2_spec <= 1'b0; r2_sign <= 1'b0;
      r2_sres <= '0; r2_sflg <= '0; r2_exp <= '0; r2_sum <= '0; r2_prod <= '0;
      r3_v <= 1'b0; r3_res <= '0; r3_flg <= '0;
    end else if (w_en) begin
      r1_v <= bus.in_valid;
      r2_v <= r1_v;
      r3_v <= r2_v;
      if (bus.in_valid) begin
        r1_mul  <= w_mul;
        r1_spec <= w_spec;
        r1_sres <= w_sres;
        r1_sflg <= w_sflg;
        r1_sa   <= w_sa;
        r1_sb   <= w_sb;
        r1_ea   <= w_ea;
        r1_eb   <= w_eb;
        r1_ma   <= {1'b1, w_fa};
        r1_mb   <= {1'b1, w_fb};
        r1_mexp <= w_mexp;
      end
      if (r1_v) begin
        r2_mul  <= r1_mul;
        r2_spec <= r1_spec;
        r2_sres <= r1_sres;
        r2_sflg <= r1_sflg;
        r2_sign <= r1_mul ? (r1_sa ^ r1_sb) : w_s_big;
        r2_exp  <= r1_mul ? r1_mexp : $signed({2'b00, w_e_big});
        r2_sum  <= w_sum;
        r2_prod <= w_prod;
      end
      if (r2_v) begin
        r3_res <= w_res;
        r3_flg <= w_flg;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fpu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fpu_pipe : scoreboard bench for fpu_pipe (single and half precision)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fpu_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpu_pipe_if #(.EXP_W(8), .MAN_W(23)) bs ();
  fpu_pipe_if #(.EXP_W(5), .MAN_W(10)) bh ();

  fpu_pipe #(.EXP_W(8), .MAN_W(23)) dut   (.clk(clk), .reset(reset), .bus(bs.slave));
  fpu_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .reset(reset), .bus(bh.slave));

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [34:0] q[$];
  logic [18:0] qh[$];

  always @(negedge clk) begin : mon_s
    logic [34:0] e;
    if (reset && bs.out_valid && bs.out_ready) begin
      n_out++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got %h flags %b, expected no result", bs.Result, bs.flags);
      end else begin
        e = q.pop_front();
        if ({bs.Result, bs.flags} !== e) begin
          errors++;
          $display("FAIL sb_result got %h flags %b, expected %h flags %b",
                   bs.Result, bs.flags, e[34:3], e[2:0]);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_h
    logic [18:0] e;
    if (reset && bh.out_valid && bh.out_ready) begin
      checks++;
      if (qh.size() == 0) begin
        errors++;
        $display("FAIL sb_half_extra got %h flags %b, expected no result", bh.Result, bh.flags);
      end else begin
        e = qh.pop_front();
        if ({bh.Result, bh.flags} !== e) begin
          errors++;
          $display("FAIL sb_half_result got %h flags %b, expected %h flags %b",
                   bh.Result, bh.flags, e[18:3], e[2:0]);
        end
      end
    end
  end

  // Present one op (called just after a rising edge); returns just after its accepting edge
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [2:0] f);
    int n = 0;
    bs.in_valid = 1'b1; bs.a = a; bs.b = b; bs.FPUControl = op;
    @(negedge clk);
    while (bs.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bs.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready %b, expected 1", bs.in_ready);
    end else q.push_back({r, f});
    @(posedge clk); #1;
    bs.in_valid = 1'b0;
  endtask

  task automatic send_h(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic [2:0] f);
    int n = 0;
    bh.in_valid = 1'b1; bh.a = a; bh.b = b; bh.FPUControl = op;
    @(negedge clk);
    while (bh.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bh.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_h_timeout in_ready %b, expected 1", bh.in_ready);
    end else qh.push_back({r, f});
    @(posedge clk); #1;
    bh.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || qh.size() != 0) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0 || qh.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d results outstanding, expected 0", name, q.size() + qh.size());
    end
    @(posedge clk); #1;
  endtask

  // Edge count starts at 1 for the accepting edge; result must be visible after the third
  task automatic op_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic [2:0] f);
    int cyc = 1;
    send(op, a, b, r, f);
    @(negedge clk);
    while (bs.out_valid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL latency got %0d edges, expected 3 (op %b a %h)", cyc, op, a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks += 3;
    if (bs.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b, expected 0", bs.out_valid); end
    if (bs.Result !== 32'h0)   begin errors++; $display("FAIL rst_result got %h, expected 00000000", bs.Result); end
    if (bs.flags !== 3'b000)   begin errors++; $display("FAIL rst_flags got %b, expected 000", bs.flags); end
    #5 reset = 1'b1;
    #1;
    checks++;
    if (bs.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b, expected 1", bs.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    op_latency(2'b00, 32'h3f800000, 32'h40000000, 32'h40400000, 3'b000);
    op_latency(2'b10, 32'h3fc00000, 32'h40000000, 32'h40400000, 3'b000);
    op_latency(2'b01, 32'h40400000, 32'h3f800000, 32'h40000000, 3'b000);
    drain("latency");
  endtask

  task automatic test_back_to_back();
    int base = n_out;
    fork
      begin
        send(2'b00, 32'h3f800000, 32'h40000000, 32'h40400000, 3'b000);
        send(2'b10, 32'h3fc00000, 32'h40000000, 32'h40400000, 3'b000);
        send(2'b01, 32'h40400000, 32'h3f800000, 32'h40000000, 3'b000);
        send(2'b00, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
        send(2'b10, 32'h40000000, 32'h40400000, 32'h40c00000, 3'b000);
        send(2'b01, 32'h3f800000, 32'h40000000, 32'hbf800000, 3'b000);
      end
      begin
        int n = 0;
        logic [31:0] held_r;
        logic [2:0]  held_f;
        @(negedge clk);
        while (bs.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bs.out_ready = 1'b0;
        held_r = bs.Result;
        held_f = bs.flags;
        repeat (4) begin
          @(negedge clk);
          checks += 3;
          if (bs.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %b, expected 0", bs.in_ready); end
          if (bs.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b, expected 1", bs.out_valid); end
          if ({bs.Result, bs.flags} !== {held_r, held_f}) begin
            errors++;
            $display("FAIL b2b_hold got %h/%b, expected %h/%b", bs.Result, bs.flags, held_r, held_f);
          end
        end
        @(posedge clk); #1;
        bs.out_ready = 1'b1;
      end
    join
    drain("b2b");
    checks++;
    if (n_out - base != 6) begin errors++; $display("FAIL b2b_count got %0d results, expected 6", n_out - base); end
  endtask

  task automatic test_specials();
    send(2'b01, 32'h7f800000, 32'h7f800000, 32'h7fc00000, 3'b100);
    send(2'b10, 32'h00000000, 32'hff800000, 32'h7fc00000, 3'b100);
    send(2'b00, 32'h7fc00001, 32'h3f800000, 32'h7fc00000, 3'b000);
    send(2'b01, 32'h3f800000, 32'h3f800000, 32'h00000000, 3'b000);
    send(2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
    send(2'b00, 32'h7f800000, 32'h3f800000, 32'h7f800000, 3'b000);
    drain("specials");
  endtask

  task automatic test_range();
    send(2'b10, 32'h7f7fffff, 32'h40000000, 32'h7f800000, 3'b010);
    send(2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
    send(2'b00, 32'h00000001, 32'h3f800000, 32'h3f800000, 3'b000);
    send(2'b00, 32'h3f800000, 32'h33800000, 32'h3f800000, 3'b000);
    send(2'b11, 32'h3f800000, 32'h3f800000, 32'h7fc00000, 3'b100);
    send(2'b00, 32'h3f800000, 32'h3f800000, 32'h40000000, 3'b000);
    drain("range");
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    send(2'b00, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    send(2'b10, 32'h40000000, 32'h40400000, 32'h40c00000, 3'b000);
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (bs.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b, expected 0", bs.out_valid); end
    if (bs.Result !== 32'h0)   begin errors++; $display("FAIL mid_result got %h, expected 00000000", bs.Result); end
    if (bs.flags !== 3'b000)   begin errors++; $display("FAIL mid_flags got %b, expected 000", bs.flags); end
    @(posedge clk); #3;
    reset = 1'b1;
    q.delete();
    qh.delete();
    repeat (6) begin
      @(negedge clk);
      if (bs.out_valid === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_stale got %0d valid cycles, expected 0", stale); end
    @(posedge clk); #1;
    op_latency(2'b00, 32'h40000000, 32'h3f800000, 32'h40400000, 3'b000);
    drain("reset_mid");
  endtask

  task automatic test_half();
    send_h(2'b00, 16'h3c00, 16'h4000, 16'h4200, 3'b000);
    send_h(2'b10, 16'h7bff, 16'h4000, 16'h7c00, 3'b010);
    send_h(2'b11, 16'h3c00, 16'h3c00, 16'h7e00, 3'b100);
    drain("half");
  endtask

  initial begin
    bs.in_valid = 1'b0; bs.a = '0; bs.b = '0; bs.FPUControl = 2'b00; bs.out_ready = 1'b1;
    bh.in_valid = 1'b0; bh.a = '0; bh.b = '0; bh.FPUControl = 2'b00; bh.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_specials();
    test_range();
    test_reset_mid();
    test_half();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit, expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
